// File: rtl/light_sequencer.sv
// light_sequencer - LED brightness sequencer: OFF/ON/BREATHE/BLINK mode FSM, prescaled level generator, PWM.
// Config is double-buffered in a one-entry pending slot that is applied only at period boundaries.
module light_sequencer #(
  parameter int unsigned W        = 8,
  parameter int unsigned DIV_W    = 16,
  parameter int unsigned DEF_DIV  = 10,
  parameter int unsigned DEF_PEAK = 255
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [1:0]       cfg_mode_i,
  input  logic [DIV_W-1:0] cfg_div_i,
  input  logic [W-1:0]     cfg_peak_i,
  output logic [W-1:0]     level_o,
  output logic             pwm_out_o,
  output logic             period_done_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    MODE_OFF     = 2'd0,
    MODE_ON      = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  // PWM counter runs 0..2^W-2 so level 2^W-1 yields a constant-high output.
  localparam logic [W-1:0] PWM_LAST = {{(W-1){1'b1}}, 1'b0};

  mode_e            mode_q, mode_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [W-1:0]     peak_q, peak_d;
  logic [W-1:0]     level_q, level_d;
  logic             dir_q, dir_d;
  logic [DIV_W-1:0] t_cnt_q, t_cnt_d;
  logic [W-1:0]     pwm_cnt_q, pwm_cnt_d;
  logic             pend_valid_q, pend_valid_d;
  mode_e            pend_mode_q, pend_mode_d;
  logic [DIV_W-1:0] pend_div_q, pend_div_d;
  logic [W-1:0]     pend_peak_q, pend_peak_d;
  logic             pwm_q, pwm_d;
  logic             period_done_q, period_done_d;
  logic             busy_q, busy_d;

  logic tick;
  logic period_end;
  logic capture;
  logic apply;

  assign tick    = en_i & (t_cnt_q == div_q);
  assign capture = cfg_valid_i & ~pend_valid_q;

  always_comb begin
    period_end = 1'b0;
    case (mode_q)
      MODE_BREATHE: period_end = tick & ((peak_q == '0) | (dir_q & (level_q == '0)));
      MODE_BLINK:   period_end = tick & dir_q;
      default:      period_end = 1'b0;
    endcase
  end

  // Steady modes take new settings immediately; ramping modes wait for their period end.
  assign apply = pend_valid_q &
                 (((mode_q == MODE_OFF) | (mode_q == MODE_ON)) ? 1'b1 : period_end);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mode_q        <= MODE_OFF;
      div_q         <= DIV_W'(DEF_DIV);
      peak_q        <= W'(DEF_PEAK);
      level_q       <= '0;
      dir_q         <= 1'b0;
      t_cnt_q       <= '0;
      pwm_cnt_q     <= '0;
      pend_valid_q  <= 1'b0;
      pend_mode_q   <= MODE_OFF;
      pend_div_q    <= '0;
      pend_peak_q   <= '0;
      pwm_q         <= 1'b0;
      period_done_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      mode_q        <= mode_d;
      div_q         <= div_d;
      peak_q        <= peak_d;
      level_q       <= level_d;
      dir_q         <= dir_d;
      t_cnt_q       <= t_cnt_d;
      pwm_cnt_q     <= pwm_cnt_d;
      pend_valid_q  <= pend_valid_d;
      pend_mode_q   <= pend_mode_d;
      pend_div_q    <= pend_div_d;
      pend_peak_q   <= pend_peak_d;
      pwm_q         <= pwm_d;
      period_done_q <= period_done_d;
      busy_q        <= busy_d;
    end
  end

  always_comb begin
    mode_d       = mode_q;
    div_d        = div_q;
    peak_d       = peak_q;
    level_d      = level_q;
    dir_d        = dir_q;
    t_cnt_d      = t_cnt_q;
    pend_valid_d = pend_valid_q;
    pend_mode_d  = pend_mode_q;
    pend_div_d   = pend_div_q;
    pend_peak_d  = pend_peak_q;
    pwm_cnt_d    = (pwm_cnt_q == PWM_LAST) ? '0 : pwm_cnt_q + W'(1);

    if (en_i) begin
      t_cnt_d = tick ? '0 : t_cnt_q + DIV_W'(1);
    end

    // dir_q: 0 = rising / at zero, 1 = falling / at peak.
    if (tick) begin
      case (mode_q)
        MODE_OFF: level_d = '0;
        MODE_ON:  level_d = peak_q;
        MODE_BREATHE: begin
          if (peak_q == '0) begin
            level_d = '0;
            dir_d   = 1'b0;
          end else if (!dir_q) begin
            if (level_q == peak_q) begin
              dir_d   = 1'b1;
              level_d = peak_q - W'(1);
            end else begin
              level_d = level_q + W'(1);
            end
          end else begin
            if (level_q == '0) begin
              dir_d   = 1'b0;
              level_d = W'(1);
            end else begin
              level_d = level_q - W'(1);
            end
          end
        end
        MODE_BLINK: begin
          level_d = dir_q ? '0 : peak_q;
          dir_d   = ~dir_q;
        end
        default: level_d = level_q;
      endcase
    end

    if (capture) begin
      pend_valid_d = 1'b1;
      pend_mode_d  = mode_e'(cfg_mode_i);
      pend_div_d   = cfg_div_i;
      pend_peak_d  = cfg_peak_i;
    end

    if (apply) begin
      mode_d       = pend_mode_q;
      div_d        = pend_div_q;
      peak_d       = pend_peak_q;
      level_d      = (pend_mode_q == MODE_ON) ? pend_peak_q : '0;
      dir_d        = 1'b0;
      t_cnt_d      = '0;
      pend_valid_d = 1'b0;
    end
  end

  always_comb begin
    period_done_d = period_end;
    busy_d        = (mode_d != MODE_OFF);
    pwm_d         = en_i & (pwm_cnt_q < level_q);
  end

  assign cfg_ready_o   = ~pend_valid_q;
  assign level_o       = level_q;
  assign pwm_out_o     = pwm_q;
  assign period_done_o = period_done_q;
  assign busy_o        = busy_q;

endmodule

// File: tb/tb_light_sequencer.sv
// tb/tb_light_sequencer.sv - directed + random bench for light_sequencer against a phase-based reference model.
module tb_light_sequencer;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        en;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [1:0]  cfg_mode;
  logic [15:0] cfg_div;
  logic [7:0]  cfg_peak;
  logic [7:0]  level;
  logic        pwm_out;
  logic        period_done;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  light_sequencer dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .en_i         (en),
    .cfg_valid_i  (cfg_valid),
    .cfg_ready_o  (cfg_ready),
    .cfg_mode_i   (cfg_mode),
    .cfg_div_i    (cfg_div),
    .cfg_peak_i   (cfg_peak),
    .level_o      (level),
    .pwm_out_o    (pwm_out),
    .period_done_o(period_done),
    .busy_o       (busy)
  );

  always #5 clk = ~clk;

  // Model: a period is a phase count s; breathe level is the triangle of s, blink level is s ? peak : 0.
  typedef struct {
    int mode;
    int div;
    int peak;
  } cfg_t;

  int   m_mode, m_div, m_peak, m_s, m_tcnt, m_pwmcnt;
  bit   m_pwm, m_done;
  cfg_t pend_q[$];

  function automatic int m_level();
    case (m_mode)
      1:       return m_peak;
      2:       return (m_peak == 0) ? 0 : ((m_s <= m_peak) ? m_s : 2 * m_peak - m_s);
      3:       return (m_s != 0) ? m_peak : 0;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_mode = 0; m_div = 10; m_peak = 255; m_s = 0; m_tcnt = 0; m_pwmcnt = 0;
    m_pwm = 0; m_done = 0;
    pend_q.delete();
  endtask

  task automatic model_step();
    int   lvl;
    bit   tick, done, had_pend;
    int   ns;
    cfg_t c;
    lvl      = m_level();
    tick     = en && (m_tcnt == m_div);
    done     = 0;
    ns       = m_s;
    had_pend = (pend_q.size() > 0);
    if (tick && m_mode == 2) begin
      if (m_peak == 0) done = 1;
      else begin
        ns = m_s + 1;
        if (ns == 2 * m_peak + 1) begin ns = 1; done = 1; end
      end
    end else if (tick && m_mode == 3) begin
      ns   = 1 - m_s;
      done = (m_s == 1);
    end
    m_pwm    = en && (m_pwmcnt < lvl);
    m_pwmcnt = (m_pwmcnt + 1) % 255;
    if (en) m_tcnt = tick ? 0 : m_tcnt + 1;
    m_s    = ns;
    m_done = done;
    if (had_pend && (m_mode < 2 || done)) begin
      c = pend_q.pop_front();
      m_mode = c.mode; m_div = c.div; m_peak = c.peak; m_s = 0; m_tcnt = 0;
    end else if (!had_pend && cfg_valid) begin
      c.mode = int'(cfg_mode); c.div = int'(cfg_div); c.peak = int'(cfg_peak);
      pend_q.push_back(c);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".level"}, 32'(level), 32'(m_level()));
    chk({tag, ".pwm"}, 32'(pwm_out), 32'(m_pwm));
    chk({tag, ".done"}, 32'(period_done), 32'(m_done));
    chk({tag, ".busy"}, 32'(busy), 32'(m_mode != 0));
    chk({tag, ".ready"}, 32'(cfg_ready), 32'(pend_q.size() == 0));
  endtask

  task automatic cycle(input string tag);
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic send(input string tag, input int mode, input int div, input int peak);
    cfg_valid = 1'b1;
    cfg_mode  = 2'(mode);
    cfg_div   = 16'(div);
    cfg_peak  = 8'(peak);
    cycle(tag);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int hi;
    rst_ni = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_mode = '0; cfg_div = '0; cfg_peak = '0;
    model_reset();
    #2;
    check_all("reset");
    @(posedge clk); #1;
    check_all("reset_hold");
    rst_ni = 1'b1;
    en = 1'b1;

    // ON at peak 128: exactly 128 high clocks in any 255-clock window once settled.
    send("t1_cfg", 1, 0, 128);
    cycle("t1_apply");
    chk("t1_level", 32'(level), 32'd128);
    cycle("t1_settle");
    hi = 0;
    for (int i = 0; i < 255; i++) begin
      cycle("t1_run");
      hi += int'(pwm_out);
    end
    chk("t1_pwm_count", 32'(hi), 32'd128);

    // BREATHE peak=4 div=0
    send("t2_cfg", 2, 0, 4);
    for (int i = 0; i < 24; i++) cycle("t2_run");

    // BREATHE peak=4 div=2, then en low for 10 clocks
    send("t3_cfg", 2, 2, 4);
    for (int i = 0; i < 40; i++) cycle("t3_run");
    en = 1'b0;
    for (int i = 0; i < 10; i++) cycle("t3_freeze");
    en = 1'b1;
    for (int i = 0; i < 20; i++) cycle("t3_resume");

    // Mid-ramp BLINK request waits for the period boundary
    send("t4_pre", 2, 0, 4);
    while (!(m_mode == 2 && m_level() == 2 && m_s == 2)) cycle("t4_seek");
    send("t4_cfg", 3, 0, 5);
    for (int i = 0; i < 20; i++) cycle("t4_run");

    // BREATHE peak=0, cfg_valid held high while pending is full
    send("t5_pre", 2, 3, 0);
    for (int i = 0; i < 6; i++) cycle("t5_run");
    cfg_valid = 1'b1; cfg_mode = 2'd2; cfg_div = 16'd3; cfg_peak = 8'd0;
    for (int i = 0; i < 12; i++) cycle("t5_hold");
    cfg_valid = 1'b0;
    for (int i = 0; i < 6; i++) cycle("t5_after");

    // Async reset mid-ramp with a pending entry
    send("t6_pre", 2, 1, 6);
    for (int i = 0; i < 9; i++) cycle("t6_run");
    send("t6_cfg", 3, 0, 7);
    #3;
    rst_ni = 1'b0;
    model_reset();
    #1;
    check_all("t6_async");
    @(posedge clk); #1;
    check_all("t6_hold");
    #2;
    rst_ni = 1'b1;

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      en        = ($urandom % 8) != 0;
      cfg_valid = ($urandom % 6) == 0;
      cfg_mode  = 2'($urandom % 4);
      cfg_div   = 16'($urandom % 4);
      cfg_peak  = (($urandom % 16) == 0) ? 8'd255 : 8'($urandom % 7);
      cycle("rand");
    end
    cfg_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
